crono_ctrl: RTL
===============

Name: crono_ctrl

Overview:
- Control sequencer for the seconds counter datapath in the stopwatch/timer design. Stopwatch mode counts up from 0 to a limit; timer mode counts down from a preset to 0.
- Turns start/pause and clear buttons into load, enable and direction strobes for the counter, and generates the 1 s tick.
- Watches the counter's value and stops it at the terminal count. Raises done/alarm for the display and buzzer logic.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per counted second (50 MHz board clock).
- W, 8, width of the seconds value and preset.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_start  in  1  start/pause button, active-high, already debounced and synchronous to clk.
- btn_clear  in  1  clear button, active-high, already debounced and synchronous to clk.
- sel  in  1  mode: 0 stopwatch (up), 1 timer (down).
- tempo  in  W  stopwatch limit / timer preset.
- cnt_value  in  W  current counter value, fed back from the datapath.
- cnt_load  out  1  one-cycle strobe: counter loads load_value.
- load_value  out  W  value to load: the latched tempo if the mode is timer, otherwise 0.
- cnt_en  out  1  one-cycle strobe: counter steps once.
- cnt_up  out  1  direction: 1 = increment, 0 = decrement; equals NOT latched sel.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  one-cycle pulse on entry to DONE.
- alarm  out  1  high while in DONE.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Edge detection: btn_start and btn_clear each go through one register stage. An event is a rising edge (current=1, previous=0). Holding a button fires only once.
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All strobes, running, paused, done and alarm = 0.
  - Prescaler = 0; latched sel/tempo = 0; edge registers = 0.
- States and encoding: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.
- Clear has priority in every state. A clear event sends the next state to LOAD if sel_l=1, otherwise to IDLE; in both cases the prescaler resets to 0. Clear does not change the latched values.
- IDLE: on a start event, latch sel→sel_l and tempo→tempo_l, then go to LOAD. sel/tempo changes at any other time are ignored.
- LOAD (exactly 1 cycle):
  - cnt_load=1 and load_value=(sel_l ? tempo_l : 0); prescaler=0.
  - From the clear path the next state is IDLE; from the start path it is RUN.
- RUN:
  - Terminal check each cycle: target = sel_l ? 0 : tempo_l. If cnt_value==target, go to DONE next cycle with no cnt_en. The terminal check takes priority over the tick.
  - Otherwise the prescaler increments. When it equals TICKS_PER_SEC-1 it wraps to 0, and cnt_en=1 in the same cycle.
  - The first cnt_en comes TICKS_PER_SEC cycles after entering RUN (counting the first RUN cycle as cycle 1).
  - A start event goes to PAUSE; a tick in that same cycle is suppressed and the prescaler holds.
- PAUSE: the prescaler holds its value and cnt_en=0. A start event returns to RUN, and the prescaler resumes from the held value (partial second preserved).
- DONE: alarm=1; done=1 only in the first DONE cycle. A start event re-latches sel/tempo and goes to LOAD (restart).
- Zero-length run:
  - Timer with tempo=0, or stopwatch with tempo=0, enters DONE on the first RUN cycle.
  - No cnt_en is ever issued in that case.
- Strobes: cnt_load and cnt_en are never high in the same cycle. No strobe is high outside LOAD (cnt_load) or RUN (cnt_en).
- Mid-operation reset: returns to IDLE immediately. Outputs are deasserted asynchronously.

Test Plan:
- Use TICKS_PER_SEC=4, W=8 throughout.
- Stopwatch, sel=0, tempo=3, start pulse, model counter attached:
  - LOAD cycle shows cnt_load=1, load_value=0.
  - cnt_en pulses every 4 cycles, 3 times.
  - done pulses once when cnt_value=3; alarm stays high.
- Timer, sel=1, tempo=5, start:
  - load_value=5, cnt_up=0.
  - 5 cnt_en pulses, then DONE at cnt_value=0.
  - Changing tempo to 9 mid-run has no effect.
- Pause/resume: start, wait 2 cycles into a second, start again (PAUSE), hold 10 cycles, start again. No cnt_en during PAUSE; the next cnt_en comes 2 cycles after resume.
- Clear during RUN in timer mode with tempo=7: next state is LOAD with cnt_load=1, load_value=7, then IDLE. Clear and start asserted in the same cycle goes the clear path.
- Timer with tempo=0, start: DONE on the cycle after the first RUN cycle, with no cnt_en ever issued.
- rst_n low mid-RUN (asynchronous, between clock edges):
  - running, alarm, cnt_en and state drop to 0 immediately.
  - After release, a held btn_start does not start the block; a fresh edge does.

Source files
------------

// File: rtl/crono_ctrl.sv
// crono_ctrl: control sequencer for the stopwatch/timer seconds counter.
//
// Converts the start/pause and clear buttons into load, enable and
// direction strobes for an external seconds counter. Generates the 1 s tick
// from a prescaler, watches the fed-back counter value for the terminal
// count, and raises done/alarm.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   btn_start           start/pause button (debounced, synchronous)
//   btn_clear           clear button (debounced, synchronous)
//   sel                 mode: 0 stopwatch (count up), 1 timer (count down)
//   tempo[W]            stopwatch limit / timer preset
//   cnt_value[W]        current counter value from the datapath
//   cnt_load            one-cycle load strobe (LOAD state)
//   load_value[W]       latched tempo in timer mode, otherwise 0
//   cnt_en              one-cycle step strobe (1 s tick in RUN)
//   cnt_up              count direction, NOT latched sel
//   running, paused     state flags for RUN / PAUSE
//   done                one-cycle pulse on entry to DONE
//   alarm               high while in DONE
//   state[3]            FSM state for debug (IDLE=0 .. DONE=4)

module crono_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 32'd50000000,
  parameter int unsigned W             = 32'd8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start,
  input  logic         btn_clear,
  input  logic         sel,
  input  logic [W-1:0] tempo,
  input  logic [W-1:0] cnt_value,
  output logic         cnt_load,
  output logic [W-1:0] load_value,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         running,
  output logic         paused,
  output logic         done,
  output logic         alarm,
  output logic [2:0]   state
);

  localparam int unsigned PW = (TICKS_PER_SEC > 32'd1) ? $clog2(TICKS_PER_SEC) : 32'd1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 32'd1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sel_l_q, sel_l_d;
  logic [W-1:0]  tempo_l_q, tempo_l_d;
  logic          from_clr_q, from_clr_d;
  logic          done_q, done_d;
  logic          start_q, clear_q, armed_q;

  logic          start_ev_s, clear_ev_s, term_s, tick_s, cnt_en_s;
  logic [W-1:0]  target_s;

  // armed_q blocks edge detection for the first cycle after reset, so a
  // button already held while reset is released is not taken as a press.
  assign start_ev_s = btn_start & ~start_q & armed_q;
  assign clear_ev_s = btn_clear & ~clear_q & armed_q;

  // Stopwatch stops at the limit, timer stops at zero.
  assign target_s = sel_l_q ? {W{1'b0}} : tempo_l_q;
  assign term_s   = (cnt_value == target_s);
  assign tick_s   = (presc_q == PRESC_MAX);

  // Button history registers for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      clear_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= btn_start;
      clear_q <= btn_clear;
      armed_q <= 1'b1;
    end
  end

  // Next-state, prescaler and latch logic; clear overrides every state.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    sel_l_d    = sel_l_q;
    tempo_l_d  = tempo_l_q;
    from_clr_d = from_clr_q;
    cnt_en_s   = 1'b0;
    if (clear_ev_s) begin
      state_d    = sel_l_q ? ST_LOAD : ST_IDLE;
      presc_d    = {PW{1'b0}};
      from_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ev_s) begin
            sel_l_d    = sel;
            tempo_l_d  = tempo;
            from_clr_d = 1'b0;
            state_d    = ST_LOAD;
          end else begin
            state_d = state_q;
          end
        end
        ST_LOAD: begin
          presc_d = {PW{1'b0}};
          state_d = from_clr_q ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          // Terminal count wins over both pause and tick.
          if (term_s) begin
            state_d = ST_DONE;
          end else if (start_ev_s) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            presc_d  = {PW{1'b0}};
            cnt_en_s = 1'b1;
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        ST_PAUSE: begin
          if (start_ev_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // FSM state, prescaler, latched setup and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= {PW{1'b0}};
      sel_l_q    <= 1'b0;
      tempo_l_q  <= {W{1'b0}};
      from_clr_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sel_l_q    <= sel_l_d;
      tempo_l_q  <= tempo_l_d;
      from_clr_q <= from_clr_d;
      done_q     <= done_d;
    end
  end

  assign cnt_load   = (state_q == ST_LOAD);
  assign load_value = sel_l_q ? tempo_l_q : {W{1'b0}};
  assign cnt_en     = cnt_en_s;
  assign cnt_up     = ~sel_l_q;
  assign running    = (state_q == ST_RUN);
  assign paused     = (state_q == ST_PAUSE);
  assign alarm      = (state_q == ST_DONE);
  assign done       = done_q;
  assign state      = state_q;

endmodule
